issue_throttle: RTL and testbench

ISSUE_THROTTLE -- requirements
Module: issue_throttle

---
 rtl/issue_throttle.sv | 130 +++++++++++++
 tb/tb_issue_throttle.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_throttle.sv
// issue_throttle: tracks ROB / RS / LSB occupancy at issue time and blocks
// issue when any structure is full. Also counts stalled fetch cycles and
// keeps a sticky error flag for counter underflow or overflow attempts.
//
// Handshake: an instruction is accepted (issue_fire) in any cycle where the
// fetcher presents one (fetch_ready) and no structure is full; there is no
// registered stage between the two, so acceptance has zero latency.
module issue_throttle #(
    parameter int ROB_SIZE = 16,
    parameter int RS_SIZE  = 16,
    parameter int LSB_SIZE = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             fetch_ready,
    input  logic             fetch_is_ls,
    input  logic             rob_commit,
    input  logic             rs_release,
    input  logic             lsb_release,
    input  logic             flush,
    output logic             is_any_full,
    output logic             issue_fire,
    output logic [2:0]       full_reason,
    output logic [CNT_W-1:0] rob_count,
    output logic [CNT_W-1:0] rs_count,
    output logic [CNT_W-1:0] lsb_count,
    output logic [31:0]      stall_cycles,
    output logic             err
);

    localparam logic [CNT_W-1:0] ROB_MAX = CNT_W'(ROB_SIZE);
    localparam logic [CNT_W-1:0] RS_MAX  = CNT_W'(RS_SIZE);
    localparam logic [CNT_W-1:0] LSB_MAX = CNT_W'(LSB_SIZE);

    logic [CNT_W-1:0] rob_count_q, rob_count_d;
    logic [CNT_W-1:0] rs_count_q,  rs_count_d;
    logic [CNT_W-1:0] lsb_count_q, lsb_count_d;
    logic [31:0]      stall_q,     stall_d;
    logic             err_q,       err_d;

    logic             rob_full, rs_full, lsb_full;
    logic [CNT_W:0]   rob_nxt, rs_nxt, lsb_nxt;

    // Returns {fault, next_count}. Simultaneous increment and release cancel.
    // A lone release at zero or a lone increment at capacity is dropped and
    // flagged as a fault.
    function automatic logic [CNT_W:0] next_cnt(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             rel,
        input logic [CNT_W-1:0] max
    );
        logic [CNT_W:0] r;
        r = {1'b0, cnt};
        if (inc && !rel) begin
            if (cnt >= max) r = {1'b1, cnt};
            else            r = {1'b0, cnt + 1'b1};
        end else if (rel && !inc) begin
            if (cnt == '0)  r = {1'b1, cnt};
            else            r = {1'b0, cnt - 1'b1};
        end
        return r;
    endfunction

    // Full flags and issue acceptance, straight from the registered counters.
    always_comb begin
        rob_full    = (rob_count_q >= ROB_MAX);
        rs_full     = (rs_count_q  >= RS_MAX);
        lsb_full    = (lsb_count_q >= LSB_MAX);
        full_reason = {lsb_full, rs_full, rob_full};
        is_any_full = rob_full | rs_full | lsb_full;
        issue_fire  = fetch_ready & ~is_any_full;
    end

    // Next-state for counters, stall counter and sticky error.
    always_comb begin
        rob_count_d = rob_count_q;
        rs_count_d  = rs_count_q;
        lsb_count_d = lsb_count_q;
        stall_d     = stall_q;
        err_d       = err_q;
        rob_nxt     = next_cnt(rob_count_q, issue_fire, rob_commit, ROB_MAX);
        rs_nxt      = next_cnt(rs_count_q, issue_fire & ~fetch_is_ls,
                               rs_release, RS_MAX);
        lsb_nxt     = next_cnt(lsb_count_q, issue_fire & fetch_is_ls,
                               lsb_release, LSB_MAX);
        if (rdy) begin
            if (flush) begin
                // Flush empties everything and leaves stall/err untouched.
                rob_count_d = '0;
                rs_count_d  = '0;
                lsb_count_d = '0;
            end else begin
                rob_count_d = rob_nxt[CNT_W-1:0];
                rs_count_d  = rs_nxt[CNT_W-1:0];
                lsb_count_d = lsb_nxt[CNT_W-1:0];
                err_d       = err_q | rob_nxt[CNT_W] | rs_nxt[CNT_W]
                                    | lsb_nxt[CNT_W];
                if (fetch_ready && is_any_full && (stall_q != 32'hFFFF_FFFF))
                    stall_d = stall_q + 32'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_count_q <= '0;
            rs_count_q  <= '0;
            lsb_count_q <= '0;
            stall_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rob_count_q <= rob_count_d;
            rs_count_q  <= rs_count_d;
            lsb_count_q <= lsb_count_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    assign rob_count    = rob_count_q;
    assign rs_count     = rs_count_q;
    assign lsb_count    = lsb_count_q;
    assign stall_cycles = stall_q;
    assign err          = err_q;

endmodule

// File: tb/tb_issue_throttle.sv
// Bench for issue_throttle: directed scenarios plus a random phase, with an
// expected-state queue filled at drive time and drained after each edge.
module tb_issue_throttle;
    localparam int SZ = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_is_ls = 1'b0;
    logic        rob_commit = 1'b0;
    logic        rs_release = 1'b0;
    logic        lsb_release = 1'b0;
    logic        flush = 1'b0;
    logic        is_any_full;
    logic        issue_fire;
    logic [2:0]  full_reason;
    logic [4:0]  rob_count;
    logic [4:0]  rs_count;
    logic [4:0]  lsb_count;
    logic [31:0] stall_cycles;
    logic        err;

    issue_throttle #(
        .ROB_SIZE(SZ), .RS_SIZE(SZ), .LSB_SIZE(SZ), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_ready(fetch_ready), .fetch_is_ls(fetch_is_ls),
        .rob_commit(rob_commit), .rs_release(rs_release),
        .lsb_release(lsb_release), .flush(flush),
        .is_any_full(is_any_full), .issue_fire(issue_fire),
        .full_reason(full_reason), .rob_count(rob_count),
        .rs_count(rs_count), .lsb_count(lsb_count),
        .stall_cycles(stall_cycles), .err(err)
    );

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected state after an edge: {rob, rs, lsb, err, stall}
    logic [47:0] exp_q[$];

    // reference state
    logic [4:0]  m_rob = '0, m_rs = '0, m_lsb = '0;
    logic [31:0] m_stall = '0;
    logic        m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {fault, next} for one counter
    function automatic logic [5:0] mupd(input logic [4:0] c,
                                        input logic inc, input logic rel);
        if (inc == rel) return {1'b0, c};
        if (inc) return (c >= 5'(SZ)) ? {1'b1, c} : {1'b0, c + 5'd1};
        return (c == 5'd0) ? {1'b1, c} : {1'b0, c - 5'd1};
    endfunction

    task automatic model_reset();
        m_rob = '0; m_rs = '0; m_lsb = '0; m_stall = '0; m_err = 1'b0;
    endtask

    // one cycle: drive at negedge, check combinational outputs, predict,
    // then compare registered state after the rising edge
    task automatic step(input logic fr, input logic ls, input logic cm,
                        input logic rr, input logic lr, input logic fl,
                        input logic r);
        logic       full, fire;
        logic [5:0] a, b, c;
        logic [4:0] nr, ns, nl;
        logic [31:0] nst;
        logic       ne;
        logic [47:0] got;
        @(negedge clk);
        fetch_ready = fr; fetch_is_ls = ls; rob_commit = cm;
        rs_release = rr; lsb_release = lr; flush = fl; rdy = r;
        #1;
        full = (m_rob >= 5'(SZ)) | (m_rs >= 5'(SZ)) | (m_lsb >= 5'(SZ));
        fire = fr & ~full;
        check("is_any_full", {31'd0, is_any_full}, {31'd0, full});
        check("issue_fire", {31'd0, issue_fire}, {31'd0, fire});
        check("full_reason", {29'd0, full_reason},
              {29'd0, (m_lsb >= 5'(SZ)), (m_rs >= 5'(SZ)), (m_rob >= 5'(SZ))});
        nr = m_rob; ns = m_rs; nl = m_lsb; nst = m_stall; ne = m_err;
        if (r) begin
            if (fl) begin
                nr = '0; ns = '0; nl = '0;
            end else begin
                a = mupd(m_rob, fire, cm);
                b = mupd(m_rs, fire & ~ls, rr);
                c = mupd(m_lsb, fire & ls, lr);
                nr = a[4:0]; ns = b[4:0]; nl = c[4:0];
                ne = m_err | a[5] | b[5] | c[5];
                if (fr && full && m_stall != 32'hFFFF_FFFF) nst = m_stall + 1;
            end
        end
        exp_q.push_back({nr, ns, nl, ne, nst});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            check("rob_count", {27'd0, rob_count}, {27'd0, got[47:43]});
            check("rs_count", {27'd0, rs_count}, {27'd0, got[42:38]});
            check("lsb_count", {27'd0, lsb_count}, {27'd0, got[37:33]});
            check("err", {31'd0, err}, {31'd0, got[32]});
            check("stall_cycles", stall_cycles, got[31:0]);
            m_rob = got[47:43]; m_rs = got[42:38]; m_lsb = got[37:33];
            m_err = got[32]; m_stall = got[31:0];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rob"}, {27'd0, rob_count}, 32'd0);
        check({tag, "_rs"}, {27'd0, rs_count}, 32'd0);
        check({tag, "_lsb"}, {27'd0, lsb_count}, 32'd0);
        check({tag, "_stall"}, stall_cycles, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_full"}, {31'd0, is_any_full}, 32'd0);
        check({tag, "_reason"}, {29'd0, full_reason}, 32'd0);
    endtask

    initial begin
        logic [4:0]  s_rob, s_rs, s_lsb;
        logic [31:0] s_stall;

        // reset
        #12;
        check_all_zero("reset");
        check("reset_fire", {31'd0, issue_fire}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // fill ROB and RS with 16 non-load/store issues
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, 1);
        check("fill_rob", {27'd0, rob_count}, 32'd16);
        check("fill_rs", {27'd0, rs_count}, 32'd16);
        check("fill_full", {31'd0, is_any_full}, 32'd1);
        check("fill_reason", {29'd0, full_reason}, 32'd3);
        check("fill_nofire", {31'd0, issue_fire}, 32'd0);

        // stall five cycles, then release one ROB and one RS entry
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1);
        check("stall_5", stall_cycles, 32'd5);
        step(1, 0, 1, 1, 0, 0, 1);
        check("rel_rob", {27'd0, rob_count}, 32'd15);
        check("rel_rs", {27'd0, rs_count}, 32'd15);
        check("rel_fire", {31'd0, issue_fire}, 32'd1);

        // clear, then LSB fire and release in the same cycle at lsb=3
        step(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1, 0, 1);
        check("ls_same_lsb", {27'd0, lsb_count}, 32'd3);
        check("ls_same_rob", {27'd0, rob_count}, 32'd4);
        check("ls_same_rs", {27'd0, rs_count}, 32'd0);

        // flush priority at rob=10
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 1);
        check("pre_flush_rob", {27'd0, rob_count}, 32'd10);
        step(1, 0, 1, 0, 0, 1, 1);
        check("flush_rob", {27'd0, rob_count}, 32'd0);
        check("flush_rs", {27'd0, rs_count}, 32'd0);
        check("flush_lsb", {27'd0, lsb_count}, 32'd0);
        check("flush_full", {31'd0, is_any_full}, 32'd0);
        check("flush_err", {31'd0, err}, 32'd0);

        // RS underflow sets sticky err, which survives flush
        step(0, 0, 0, 1, 0, 0, 1);
        check("under_rs", {27'd0, rs_count}, 32'd0);
        check("under_err", {31'd0, err}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 1);
        check("sticky_err", {31'd0, err}, 32'd1);

        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) != 0);

        // rdy low holds everything
        s_rob = m_rob; s_rs = m_rs; s_lsb = m_lsb; s_stall = m_stall;
        for (int i = 0; i < 4; i++)
            step(1, 1'($urandom_range(0, 1)), 1, 1, 1, 0, 0);
        check("hold_rob", {27'd0, rob_count}, {27'd0, s_rob});
        check("hold_rs", {27'd0, rs_count}, {27'd0, s_rs});
        check("hold_lsb", {27'd0, lsb_count}, {27'd0, s_lsb});
        check("hold_stall", stall_cycles, s_stall);

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rdy = 1'b1; fetch_ready = 1'($urandom_range(0, 1));
            rob_commit = 1'($urandom_range(0, 1));
            rs_release = 1'($urandom_range(0, 1));
            flush = 1'($urandom_range(0, 1));
        end
        #1;
        check_all_zero("in_rst");
        rdy = 1'b0; fetch_ready = 1'b0; rob_commit = 1'b0;
        rs_release = 1'b0; lsb_release = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
